// File: rtl/pea_request_arbiter.sv
`timescale 1ns/1ps
// Pedestrian-phase arbiter: conditions crosswalk buttons, latches requests,
// asks the light controller for the walk phase and grants it round-robin.
module pea_request_arbiter #(
  parameter int N_REQ           = 4,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int HOLDOFF_CYCLES  = 50_000_000,
  parameter int ACK_TIMEOUT     = 500_000_000,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [N_REQ-1:0] b_npeaton,
  input  logic             phase_ack,
  input  logic             phase_done,
  output logic             phase_req,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic [N_REQ-1:0] sol_lights,
  output logic             err_timeout
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int WW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVE,
    HOLDOFF
  } state_t;

  state_t           state;
  logic [N_REQ-1:0] sync1;
  logic [N_REQ-1:0] sync2;
  logic [N_REQ-1:0] db;
  logic [DW-1:0]    dcnt [N_REQ];
  logic [N_REQ-1:0] fall;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] sel_oh;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] blk;
  logic [IW-1:0]    sel;
  logic [IW-1:0]    rr_ptr;
  logic [WW-1:0]    wcnt;
  logic [HW-1:0]    hcnt;
  logic             ack_now;

  // Synchronise and debounce each button; level flips after a stable run.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '1;
      for (int i = 0; i < N_REQ; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= b_npeaton;
      sync2 <= sync1;
      for (int i = 0; i < N_REQ; i++) begin
        if (sync2[i] != db[i]) begin
          if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            db[i]   <= sync2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + DW'(1);
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  // Press event: the edge on which the debounced level drops to 0.
  always_comb begin
    fall = '0;
    for (int i = 0; i < N_REQ; i++)
      fall[i] = db[i] & ~sync2[i] &
                (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1));
  end

  // Round-robin pick: first pending index at or after rr_ptr.
  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    logic        found;
    sel   = rr_ptr;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IW'(j);
      if (!found && pending[jj]) begin
        found = 1'b1;
        sel   = jj;
      end
    end
  end

  assign sel_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
  assign ack_now = (state == REQ) && phase_ack;
  assign clr     = ack_now ? sel_oh : '0;
  assign blk     = grant | clr;

  // Pending latch: set by presses not aimed at the served crosswalk.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) pending <= '0;
    else         pending <= (pending & ~clr) | (fall & ~blk);
  end

  assign sol_lights = pending;

  // Phase sequencing: request, grant, serve, then hold off.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      phase_req   <= 1'b0;
      grant       <= '0;
      grant_idx   <= '0;
      rr_ptr      <= '0;
      err_timeout <= 1'b0;
      wcnt        <= '0;
      hcnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pending != '0) begin
            phase_req <= 1'b1;
            wcnt      <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (phase_ack) begin
            grant     <= sel_oh;
            grant_idx <= sel;
            phase_req <= 1'b0;
            state     <= SERVE;
          end else if (wcnt == WW'(ACK_TIMEOUT - 1)) begin
            phase_req   <= 1'b0;
            err_timeout <= 1'b1;
            hcnt        <= HW'(HOLDOFF_CYCLES);
            state       <= HOLDOFF;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        SERVE: begin
          if (phase_done) begin
            grant  <= '0;
            rr_ptr <= (grant_idx == IW'(N_REQ - 1)) ?
                      '0 : grant_idx + IW'(1);
            hcnt   <= HW'(HOLDOFF_CYCLES);
            state  <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (hcnt <= HW'(1)) begin
            hcnt  <= '0;
            state <= IDLE;
          end else begin
            hcnt <= hcnt - HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
